// File: rtl/com_pkg.sv
// Shared constants, state encoding and header byte selection for the frame builder.
package com_pkg;

    localparam logic [15:0] PASSWORD = 16'h55AA;
    localparam logic [12:0] MAX_PLEN = 13'd8185;
    localparam logic [12:0] HDR_LEN  = 13'd5;
    localparam logic [12:0] TRL_LEN  = 13'd1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HEAD = 3'd1,
        LOAD = 3'd2,
        SUM  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Header byte at offset idx: sync word (high first), {btype,didx}, length high, length low.
    function automatic logic [7:0] hdr_byte(
        input logic [2:0]  idx,
        input logic [15:0] pw,
        input logic [7:0]  bd,
        input logic [12:0] len
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = pw[15:8];
            3'd1:    b = pw[7:0];
            3'd2:    b = bd;
            3'd3:    b = {3'b000, len[12:8]};
            3'd4:    b = len[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/data_pack.sv
// Builds one frame in the data RAM: 5-byte header, payload from the FIFO, 8-bit checksum,
// then reports the total length with fd. src_d is captured on the edge that ends a src_rd cycle.
module data_pack
    import com_pkg::*;
#(
    parameter logic [15:0] PASSWORD = com_pkg::PASSWORD,
    parameter logic [12:0] MAX_PLEN = com_pkg::MAX_PLEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    input  logic [3:0]  btype,
    input  logic [3:0]  didx,
    input  logic [12:0] plen,
    input  logic [15:0] base,
    output logic        src_rd,
    input  logic [7:0]  src_d,
    input  logic        src_empty,
    output logic        ram_txen,
    output logic [15:0] ram_txa,
    output logic [7:0]  ram_txd,
    output logic [12:0] data_len
);

    state_t      r_state, w_state;
    logic [7:0]  r_bd, w_bd;
    logic [12:0] r_len, w_len;
    logic [15:0] r_base, w_base;
    logic [12:0] r_off, w_off;
    logic [7:0]  r_sum, w_sum;
    logic [12:0] r_rd_cnt, w_rd_cnt;
    logic [12:0] r_wr_cnt, w_wr_cnt;
    logic        r_fd, w_fd;
    logic        r_src_rd, w_src_rd;
    logic        r_txen, w_txen;
    logic [15:0] r_txa, w_txa;
    logic [7:0]  r_txd, w_txd;
    logic [12:0] r_data_len, w_data_len;
    logic [7:0]  w_byte;

    // Next-state and next-output logic for the framing sequence.
    always_comb begin
        w_state    = r_state;
        w_bd       = r_bd;
        w_len      = r_len;
        w_base     = r_base;
        w_off      = r_off;
        w_sum      = r_sum;
        w_rd_cnt   = r_rd_cnt;
        w_wr_cnt   = r_wr_cnt;
        w_fd       = 1'b0;
        w_src_rd   = 1'b0;
        w_txen     = 1'b0;
        w_txa      = r_txa;
        w_txd      = r_txd;
        w_data_len = r_data_len;
        w_byte     = 8'h00;

        case (r_state)
            IDLE: begin
                if (fs) begin
                    w_bd     = {btype, didx};
                    w_len    = (plen > MAX_PLEN) ? MAX_PLEN : plen;
                    w_base   = base;
                    w_off    = 13'd0;
                    w_sum    = 8'h00;
                    w_rd_cnt = 13'd0;
                    w_wr_cnt = 13'd0;
                    w_state  = HEAD;
                end else begin
                    w_state  = IDLE;
                end
            end

            HEAD: begin
                w_byte = hdr_byte(r_off[2:0], PASSWORD, r_bd, r_len);
                w_txen = 1'b1;
                w_txa  = r_base + {3'b000, r_off};
                w_txd  = w_byte;
                w_off  = r_off + 13'd1;
                // The sync word is left out of the checksum.
                if (r_off >= 13'd2) begin
                    w_sum = r_sum + w_byte;
                end else begin
                    w_sum = r_sum;
                end
                if (r_off == HDR_LEN - 13'd1) begin
                    w_state = (r_len != 13'd0) ? LOAD : SUM;
                end else begin
                    w_state = HEAD;
                end
            end

            LOAD: begin
                w_src_rd = !src_empty && (r_rd_cnt < r_len);
                if (w_src_rd) begin
                    w_rd_cnt = r_rd_cnt + 13'd1;
                end else begin
                    w_rd_cnt = r_rd_cnt;
                end
                if (r_src_rd) begin
                    w_txen   = 1'b1;
                    w_txa    = r_base + {3'b000, r_off};
                    w_txd    = src_d;
                    w_sum    = r_sum + src_d;
                    w_off    = r_off + 13'd1;
                    w_wr_cnt = r_wr_cnt + 13'd1;
                    if (r_wr_cnt + 13'd1 == r_len) begin
                        w_state = SUM;
                    end else begin
                        w_state = LOAD;
                    end
                end else begin
                    w_state = LOAD;
                end
            end

            SUM: begin
                w_txen  = 1'b1;
                w_txa   = r_base + {3'b000, r_off};
                w_txd   = r_sum;
                w_off   = r_off + 13'd1;
                w_state = DONE;
            end

            DONE: begin
                w_data_len = r_len + HDR_LEN + TRL_LEN;
                // fd is held at least one cycle even if fs already dropped.
                if (r_fd && !fs) begin
                    w_fd    = 1'b0;
                    w_state = IDLE;
                end else begin
                    w_fd    = 1'b1;
                    w_state = DONE;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_bd       <= 8'h00;
            r_len      <= 13'd0;
            r_base     <= 16'h0000;
            r_off      <= 13'd0;
            r_sum      <= 8'h00;
            r_rd_cnt   <= 13'd0;
            r_wr_cnt   <= 13'd0;
            r_fd       <= 1'b0;
            r_src_rd   <= 1'b0;
            r_txen     <= 1'b0;
            r_txa      <= 16'h0000;
            r_txd      <= 8'h00;
            r_data_len <= 13'd0;
        end else begin
            r_state    <= w_state;
            r_bd       <= w_bd;
            r_len      <= w_len;
            r_base     <= w_base;
            r_off      <= w_off;
            r_sum      <= w_sum;
            r_rd_cnt   <= w_rd_cnt;
            r_wr_cnt   <= w_wr_cnt;
            r_fd       <= w_fd;
            r_src_rd   <= w_src_rd;
            r_txen     <= w_txen;
            r_txa      <= w_txa;
            r_txd      <= w_txd;
            r_data_len <= w_data_len;
        end
    end

    assign fd       = r_fd;
    assign src_rd   = r_src_rd;
    assign ram_txen = r_txen;
    assign ram_txa  = r_txa;
    assign ram_txd  = r_txd;
    assign data_len = r_data_len;

endmodule

// File: tb/tb_data_pack.sv
// Scoreboard bench for data_pack: stimulus queues expected RAM writes, fd timing and spot
// checks; a negedge monitor pops and compares them.
module tb_data_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fs = 1'b0;
    logic        fd;
    logic [3:0]  btype = 4'h0;
    logic [3:0]  didx = 4'h0;
    logic [12:0] plen = 13'd0;
    logic [15:0] base = 16'h0000;
    logic        src_rd;
    logic [7:0]  src_d;
    logic        src_empty = 1'b0;
    logic        ram_txen;
    logic [15:0] ram_txa;
    logic [7:0]  ram_txd;
    logic [12:0] data_len;

    data_pack dut (
        .clk(clk), .rst(rst_n), .fs(fs), .fd(fd), .btype(btype), .didx(didx),
        .plen(plen), .base(base), .src_rd(src_rd), .src_d(src_d), .src_empty(src_empty),
        .ram_txen(ram_txen), .ram_txa(ram_txa), .ram_txd(ram_txd), .data_len(data_len)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
    typedef struct { string nm; int act; int exp; } chk_t;

    wr_t         exp_q[$];
    int          exp_fd_cyc[$];
    int          exp_fd_len[$];
    chk_t        chk_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int unsigned rd_cnt_tb = 0;
    int unsigned frame_rd0 = 0;
    logic        chk_en = 1'b1;
    logic [7:0]  fmem [0:8191];

    // Show-ahead FIFO model: head byte is on src_d, popped on each edge with src_rd high.
    assign src_d = fmem[13'(rd_cnt_tb - frame_rd0)];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_rd) rd_cnt_tb <= rd_cnt_tb + 1;
    end

    // Monitor: the only process that compares and counts.
    initial begin
        logic fd_prev;
        wr_t  w;
        chk_t c;
        fd_prev = 1'b0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_vec++;
                if (c.act != c.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0h, want %0h", c.nm, c.act, c.exp);
                end
            end
            if (rst_n && chk_en && ram_txen) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected: got %h<=%h, want none", ram_txa, ram_txd);
                end else begin
                    w = exp_q.pop_front();
                    if ({ram_txa, ram_txd} !== {w.a, w.d}) begin
                        n_err++;
                        $display("FAIL ram_wr: got %h<=%h, want %h<=%h", ram_txa, ram_txd, w.a, w.d);
                    end
                end
            end
            if (rst_n && chk_en && fd && !fd_prev) begin
                n_vec++;
                if (exp_fd_cyc.size() == 0) begin
                    n_err++;
                    $display("FAIL fd_unexpected: got fd at cycle %0d, want none", cyc);
                end else begin
                    int ec;
                    int el;
                    ec = exp_fd_cyc.pop_front();
                    el = exp_fd_len.pop_front();
                    if (cyc != ec || int'(data_len) != el) begin
                        n_err++;
                        $display("FAIL fd_rise: got cycle %0d len %0d, want cycle %0d len %0d",
                                 cyc, data_len, ec, el);
                    end
                end
            end
            fd_prev = fd;
        end
    end

    task automatic expect_chk(input string nm, input int act, input int exp);
        chk_q.push_back('{nm, act, exp});
    endtask

    task automatic push_tbl(input logic [15:0] b, input logic [7:0] v[$]);
        foreach (v[i]) exp_q.push_back({b + 16'(i), v[i]});
    endtask

    task automatic load_fifo(input logic [7:0] v[$]);
        foreach (v[i]) fmem[i] = v[i];
    endtask

    // Drives a start at a negedge; edge 0 is the next posedge. fd_off < 0 means no fd expected.
    task automatic start_frame(input logic [15:0] b, input logic [3:0] t, input logic [3:0] d,
                               input logic [12:0] p, input int fd_off, input int dlen,
                               output int t0);
        @(negedge clk);
        base = b; btype = t; didx = d; plen = p;
        frame_rd0 = rd_cnt_tb;
        fs = 1'b1;
        t0 = cyc + 1;
        if (fd_off >= 0) begin
            exp_fd_cyc.push_back(t0 + fd_off);
            exp_fd_len.push_back(dlen);
        end
    endtask

    task automatic finish_frame(input int dlen);
        int i;
        i = 0;
        while (!fd && i < 20000) begin
            @(negedge clk);
            i++;
        end
        expect_chk("fd_seen", int'(fd), 1);
        fs = 1'b0;
        @(negedge clk);
        expect_chk("fd_fall", int'(fd), 0);
        expect_chk("len_hold", int'(data_len), dlen);
        expect_chk("wr_left", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] v[$];
        int t0;
        logic [7:0] s;

        // Reset values.
        repeat (2) @(negedge clk);
        expect_chk("rst_fd", int'(fd), 0);
        expect_chk("rst_src_rd", int'(src_rd), 0);
        expect_chk("rst_txen", int'(ram_txen), 0);
        expect_chk("rst_txa", int'(ram_txa), 0);
        expect_chk("rst_txd", int'(ram_txd), 0);
        expect_chk("rst_len", int'(data_len), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 4-byte frame.
        v = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_fifo(v);
        v = '{8'h55, 8'hAA, 8'h23, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h31};
        push_tbl(16'h0100, v);
        start_frame(16'h0100, 4'h2, 4'h3, 13'd4, 12, 10, t0);
        repeat (6) @(negedge clk);
        expect_chk("rd_c5", int'(src_rd), 0);
        @(negedge clk);
        expect_chk("rd_c6", int'(src_rd), 1);
        finish_frame(10);

        // Empty payload, fs dropped right after the start: fd still pulses.
        v = '{8'h55, 8'hAA, 8'h5A, 8'h00, 8'h00, 8'h5A};
        push_tbl(16'h0000, v);
        start_frame(16'h0000, 4'h5, 4'hA, 13'd0, 7, 6, t0);
        @(negedge clk);
        fs = 1'b0;
        finish_frame(6);

        // FIFO stall of two cycles after the first read.
        v = '{8'h10, 8'h20, 8'h30};
        load_fifo(v);
        v = '{8'h55, 8'hAA, 8'h11, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h74};
        push_tbl(16'h0200, v);
        start_frame(16'h0200, 4'h1, 4'h1, 13'd3, 13, 9, t0);
        repeat (7) @(negedge clk);
        expect_chk("stall_rd_c6", int'(src_rd), 1);
        src_empty = 1'b1;
        @(negedge clk);
        expect_chk("stall_rd_c7", int'(src_rd), 0);
        @(negedge clk);
        expect_chk("stall_rd_c8", int'(src_rd), 0);
        expect_chk("stall_txen_c8", int'(ram_txen), 0);
        src_empty = 1'b0;
        @(negedge clk);
        expect_chk("stall_txen_c9", int'(ram_txen), 0);
        finish_frame(9);

        // Address wrap at the top of the RAM.
        v = '{8'hAB, 8'hCD};
        load_fifo(v);
        v = '{8'h55, 8'hAA, 8'hF0, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h6A};
        push_tbl(16'hFFFE, v);
        start_frame(16'hFFFE, 4'hF, 4'h0, 13'd2, 10, 8, t0);
        finish_frame(8);

        // Oversized request clamps to 8185 payload bytes.
        s = 8'hC3 + 8'h1F + 8'hF9;
        for (int i = 0; i < 8185; i++) begin
            fmem[i] = 8'(i) ^ 8'h5A;
            s = s + (8'(i) ^ 8'h5A);
        end
        v = '{8'h55, 8'hAA, 8'hC3, 8'h1F, 8'hF9};
        push_tbl(16'h1000, v);
        for (int i = 0; i < 8185; i++) exp_q.push_back({16'h1005 + 16'(i), 8'(i) ^ 8'h5A});
        exp_q.push_back({16'h1000 + 16'd8190, s});
        start_frame(16'h1000, 4'hC, 4'h3, 13'd8191, 8193, 8191, t0);
        finish_frame(8191);
        expect_chk("rd_count", int'(rd_cnt_tb - frame_rd0), 8185);

        // Reset in the middle of LOAD, then a clean frame.
        v = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        load_fifo(v);
        chk_en = 1'b0;
        start_frame(16'h0300, 4'h7, 4'h1, 13'd4, -1, 0, t0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        fs = 1'b0;
        #1;
        expect_chk("mid_rst_fd", int'(fd), 0);
        expect_chk("mid_rst_src_rd", int'(src_rd), 0);
        expect_chk("mid_rst_txen", int'(ram_txen), 0);
        expect_chk("mid_rst_txa", int'(ram_txa), 0);
        expect_chk("mid_rst_txd", int'(ram_txd), 0);
        expect_chk("mid_rst_len", int'(data_len), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        v = '{8'h55, 8'hAA, 8'h71, 8'h00, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hA3};
        push_tbl(16'h0300, v);
        start_frame(16'h0300, 4'h7, 4'h1, 13'd4, 12, 10, t0);
        finish_frame(10);
        expect_chk("fd_left", exp_fd_cyc.size(), 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
